// File: rtl/alu_pkg.sv
// Shared ALU definitions for the serial subtract path.
//   - FSM state encoding (IDLE/RUN/DONE)
//   - default operand width and slice width, slice-count derivation
//   - op encoding for the optional add mode (SUB_SERIAL_ADD_MODE_EN)
package alu_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SLICE_W = 8;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // WIDTH is expected to be an integer multiple of SLICE_W.
  function automatic int nslice(input int width, input int slice_w);
    return width / slice_w;
  endfunction

  localparam int DEF_NSLICE = DEF_WIDTH / DEF_SLICE_W;

endpackage

// File: rtl/sub_serial_32_bit_if.sv
// Operand/result handshake bundle for sub_serial_32_bit.
//   in_valid/in_ready + a, b, bin (+ op with SUB_SERIAL_ADD_MODE_EN): operand side
//   out_valid/out_ready + diff, bout, ovf, zero:                     result side
// master = producer/consumer around the block, slave = the block itself.
interface sub_serial_32_bit_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
`ifdef SUB_SERIAL_ADD_MODE_EN
  logic             op;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

`ifdef SUB_SERIAL_ADD_MODE_EN
  modport master (output in_valid, a, b, bin, op, out_ready,
                  input  in_ready, out_valid, diff, bout, ovf, zero);
  modport slave  (input  in_valid, a, b, bin, op, out_ready,
                  output in_ready, out_valid, diff, bout, ovf, zero);
`else
  modport master (output in_valid, a, b, bin, out_ready,
                  input  in_ready, out_valid, diff, bout, ovf, zero);
  modport slave  (input  in_valid, a, b, bin, out_ready,
                  output in_ready, out_valid, diff, bout, ovf, zero);
`endif
endinterface

// File: rtl/sub_serial_32_bit_slice.sv
// slice_addsub: combinational W-bit adder slice.
//   x, y_in : addends (caller pre-inverts y for subtraction)
//   cin     : carry in
//   sum     : x + y_in + cin (low W bits)
//   cout    : carry out of the slice
module slice_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y_in,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y_in} + {{W{1'b0}}, cin};
endmodule

// File: rtl/sub_serial_32_bit.sv
// sub_serial_32_bit: multi-cycle two's-complement subtractor.
// Computes diff = a - b - bin one SLICE_W-bit slice per clock, LS slice first,
// carrying the inter-slice carry in a register (carry form: borrow = ~carry).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sub_serial_32_bit_if.slave (operand and result handshakes)
// Optional: define SUB_SERIAL_ADD_MODE_EN to add an op input (1 = add, 0 = sub).
module sub_serial_32_bit
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  sub_serial_32_bit_if.slave  bus
);
  localparam int NSLICE = nslice(WIDTH, SLICE_W);
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);
  localparam int MSB    = WIDTH - 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q, b_q, diff_q, diff_nx;
  logic              c_q, bout_q, ovf_q, zero_q;
  logic              op_q, op_in, sub;
  logic              accept, cin0;
  int                base;
  logic [SLICE_W-1:0] x, y, sum;
  logic              cout;

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)    state_d = RUN;
      RUN:     if (cnt_q == LAST)   state_d = DONE;
      DONE:    if (bus.out_ready)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  assign accept = (state_q == IDLE) && bus.in_valid;

`ifdef SUB_SERIAL_ADD_MODE_EN
  assign op_in = bus.op;
`else
  assign op_in = OP_SUB;
`endif

  // Initial carry: subtraction feeds ~bin (a + ~b + 1 - bin), addition feeds bin.
  assign cin0 = (op_in == OP_SUB) ? ~bus.bin : bus.bin;
  assign sub  = (op_q == OP_SUB);

  always_comb begin
    base    = int'(cnt_q) * SLICE_W;
    x       = a_q[base +: SLICE_W];
    y       = sub ? ~b_q[base +: SLICE_W] : b_q[base +: SLICE_W];
    diff_nx = diff_q;
    diff_nx[base +: SLICE_W] = sum;
  end

  slice_addsub #(.W(SLICE_W)) u_slice (
    .x    (x),
    .y_in (y),
    .cin  (c_q),
    .sum  (sum),
    .cout (cout)
  );

  // ---- datapath ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_SUB;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      op_q  <= op_in;
      c_q   <= cin0;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      diff_q <= diff_nx;
      c_q    <= cout;
      cnt_q  <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        // Flags use diff_nx so the top slice written this cycle is included.
        bout_q <= sub ? ~cout : cout;
        ovf_q  <= sub ? ((a_q[MSB] != b_q[MSB]) && (diff_nx[MSB] != a_q[MSB]))
                      : ((a_q[MSB] == b_q[MSB]) && (diff_nx[MSB] != a_q[MSB]));
        zero_q <= (diff_nx == '0);
      end
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_sub_serial_32_bit.sv
// Directed bench for sub_serial_32_bit: arithmetic vectors, latency,
// backpressure, asynchronous reset mid-operation, optional add mode.
module tb_sub_serial_32_bit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sub_serial_32_bit_if #(.WIDTH(32)) bus ();

  sub_serial_32_bit #(.WIDTH(32), .SLICE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands at negedge, handshake at next posedge; returns the number
  // of rising edges from the handshake until out_valid (99 on timeout).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input logic op);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
`ifdef SUB_SERIAL_ADD_MODE_EN
    bus.op = op;
`else
    if (op != OP_SUB) $display("note: add op requested without add mode");
`endif
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = k; break; end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input logic op, input logic [31:0] e_diff,
                        input logic e_bout, input logic e_ovf, input logic e_zero);
    int lat;
    start_op(a, b, bin, op);
    wait_done(lat);
    check({tag, ".lat"},  64'(lat), 64'd4);
    check({tag, ".diff"}, 64'(bus.diff), 64'(e_diff));
    check({tag, ".bout"}, 64'(bus.bout), 64'(e_bout));
    check({tag, ".ovf"},  64'(bus.ovf),  64'(e_ovf));
    check({tag, ".zero"}, 64'(bus.zero), 64'(e_zero));
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    check({tag, ".ovld_clr"}, 64'(bus.out_valid), 64'd0);
    check({tag, ".irdy"},     64'(bus.in_ready),  64'd1);
  endtask

  initial begin
    logic [31:0] held;
    int lat;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b0;
`ifdef SUB_SERIAL_ADD_MODE_EN
    bus.op = OP_SUB;
`endif
    #12;
    check("rst.irdy", 64'(bus.in_ready), 64'd1);
    check("rst.ovld", 64'(bus.out_valid), 64'd0);
    check("rst.diff", 64'(bus.diff), 64'd0);
    check("rst.flags", 64'({bus.bout, bus.ovf, bus.zero}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("v5m3",   32'h0000_0005, 32'h0000_0003, 1'b0, OP_SUB, 32'h0000_0002, 0, 0, 0);
    run_op("v0m1",   32'h0000_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'hFFFF_FFFF, 1, 0, 0);
    run_op("vmin",   32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'h7FFF_FFFF, 0, 1, 0);
    run_op("veq",    32'h1234_5678, 32'h1234_5678, 1'b0, OP_SUB, 32'h0000_0000, 0, 0, 1);
    run_op("vslice", 32'h0001_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'h0000_FFFF, 0, 0, 0);
    run_op("vbin",   32'h0000_0000, 32'h0000_0000, 1'b1, OP_SUB, 32'hFFFF_FFFF, 1, 0, 0);
    run_op("vpos",   32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, OP_SUB, 32'h8000_0000, 1, 1, 0);

    // Backpressure: 0x100 - 1 - 1 = 0xFE, held 10 cycles; a second request is ignored.
    start_op(32'h0000_0100, 32'h0000_0001, 1'b1, OP_SUB);
    wait_done(lat);
    check("bp.lat", 64'(lat), 64'd4);
    held = bus.diff;
    check("bp.diff", 64'(held), 64'h0000_00FE);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 3) begin bus.a = 32'hDEAD_BEEF; bus.b = 32'h1; bus.in_valid = 1'b1; end
      if (k == 6) bus.in_valid = 1'b0;
      check("bp.ovld", 64'(bus.out_valid), 64'd1);
      check("bp.hold", 64'(bus.diff), 64'(held));
      check("bp.irdy", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    check("bp.rel_ovld", 64'(bus.out_valid), 64'd0);
    check("bp.rel_irdy", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    check("bp.no_accept", 64'(bus.in_ready), 64'd1);

    // Reset after two slice cycles: everything clears without a clock edge.
    start_op(32'h0000_0005, 32'h0000_0003, 1'b0, OP_SUB);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0; #1;
    check("mrst.irdy", 64'(bus.in_ready), 64'd1);
    check("mrst.ovld", 64'(bus.out_valid), 64'd0);
    check("mrst.diff", 64'(bus.diff), 64'd0);
    check("mrst.flags", 64'({bus.bout, bus.ovf, bus.zero}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mrst.idle", 64'(bus.out_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post", 32'h0000_0010, 32'h0000_0001, 1'b1, OP_SUB, 32'h0000_000E, 0, 0, 0);

`ifdef SUB_SERIAL_ADD_MODE_EN
    run_op("add",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h0000_0000, 1, 0, 1);
    run_op("sub2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_SUB, 32'hFFFF_FFFE, 0, 0, 0);
    run_op("addo", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h8000_0000, 0, 1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sub_serial_32_bit.md
Name: sub_serial_32_bit

Overview:
- Multi-cycle two's-complement subtractor, the inverse operation of the CLA adder datapath.
- Computes DIFF = A - B - BIN one SLICE_W-bit slice per clock, least-significant slice first.
- Carries the borrow between slices in a register.
- Sits beside the combinational adder tree as the area-cheap subtract path of the ALU.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of SLICE_W.
- SLICE_W, 8, bits processed per clock; NSLICE = WIDTH/SLICE_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  out  1  unsigned borrow out (1 when a < b + bin).
- ovf  out  1  signed overflow.
- zero  out  1  diff == 0.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; in_ready=1; out_valid=0; diff=0; bout=0; ovf=0; zero=0; slice counter=0; borrow register=0. Reset mid-operation abandons the operation silently; no result is produced.
- Arithmetic per slice: carry-form subtraction. s = a_slice + ~b_slice + c, where c is the carry into the slice. Initial c = ~bin; the next slice's c is that slice's carry-out. Final bout = ~carry-out of the top slice.
- ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- zero is evaluated on the complete diff, registered with out_valid.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch a, b, bin; counter=0; go to RUN.
  - RUN: in_ready=0. Each cycle, compute slice[counter] and write it into diff[counter*SLICE_W +: SLICE_W]; increment counter. When counter==NSLICE-1, also update bout/ovf/zero, set out_valid=1 and go to DONE.
  - DONE: out_valid=1; outputs stable. On out_ready: out_valid=0 and go to IDLE.
- Latency: the in handshake happens at edge 0; out_valid rises after edge NSLICE (4 clocks for the defaults). Throughput is one result per NSLICE+2 cycles minimum.
- in_ready is purely a function of state (==IDLE). A new operation cannot be accepted in the same cycle as the out handshake.
- Input changes while not IDLE are ignored; operands stay latched.
- diff upper slices hold stale data during RUN. Consumers sample diff only when out_valid=1.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: SUB_SERIAL_ADD_MODE_EN.
- With the macro defined:
  - Extra input port op (1 bit), latched with the operands.
  - op=1 selects addition: s = a_slice + b_slice + c, initial c = bin, bout = carry-out of the top slice.
  - ovf for addition = (a[MSB]==b[MSB]) && (diff[MSB]!=a[MSB]).
  - op=0 selects subtraction as above.
- Without the macro: no op port; the block always subtracts.

Decomposition:
- Shared package, alu_pkg:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - default WIDTH and SLICE_W constants.
  - NSLICE derivation.
  - op encoding constants OP_SUB=1'b0, OP_ADD=1'b1.
- One sub-module, slice_addsub: combinational SLICE_W-bit add of x and y_in with carry-in, producing sum and carry-out. The parent handles inversion of b.

Test Plan:
- a=32'h0000_0005, b=32'h0000_0003, bin=0 -> diff=32'h0000_0002, bout=0, ovf=0, zero=0; out_valid rises exactly 4 clocks after the in handshake.
- a=0, b=1, bin=0 -> diff=32'hFFFF_FFFF, bout=1, ovf=0. Exercises borrow propagation through all 4 slices.
- a=32'h8000_0000, b=1, bin=0 -> diff=32'h7FFF_FFFF, ovf=1, bout=0. Separately: a=b=32'h1234_5678, bin=0 -> zero=1.
- Backpressure: hold out_ready=0 for 10 cycles. out_valid and diff must stay stable; in_ready stays 0; a second in_valid is ignored. Release out_ready -> in_ready=1 the next cycle.
- Reset mid-RUN: assert rst_n=0 after 2 slice cycles. All outputs go to 0 immediately (asynchronous); after release, a=32'h10, b=32'h1, bin=1 -> diff=32'hE.
- With SUB_SERIAL_ADD_MODE_EN: op=1, a=32'hFFFF_FFFF, b=1, bin=0 -> diff=0, bout=1, zero=1. Then op=0 on the same operands -> diff=32'hFFFF_FFFE, bout=0.
